// File: rtl/ssm_y_tile_assembler.sv
// Collects H_tile x P_tile output tiles in any order into a full y buffer, then streams it out flat.
// Optional FP16 NaN counting of accepted tile elements is enabled by defining SSM_Y_NAN_CHECK_EN.
module ssm_y_tile_assembler #(
  parameter int unsigned B      = 1,
  parameter int unsigned H      = 24,
  parameter int unsigned P      = 64,
  parameter int unsigned H_tile = 6,
  parameter int unsigned P_tile = 4,
  parameter int unsigned DW     = 16,
  localparam int unsigned NUM_TILE_H = H / H_tile,
  localparam int unsigned NUM_TILE_P = P / P_tile,
  localparam int unsigned NUM_TILES  = NUM_TILE_H * NUM_TILE_P,
  localparam int unsigned TOTAL      = B * H * P,
  localparam int unsigned HW = (NUM_TILE_H > 1) ? $clog2(NUM_TILE_H) : 1,
  localparam int unsigned PW = (NUM_TILE_P > 1) ? $clog2(NUM_TILE_P) : 1,
  localparam int unsigned IW = $clog2(TOTAL),
  localparam int unsigned TE = H_tile * P_tile
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               tile_valid,
  output logic               tile_ready,
  input  logic [HW-1:0]      tile_h_idx,
  input  logic [PW-1:0]      tile_p_idx,
  input  logic [TE*DW-1:0]   y_tile,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [IW-1:0]      out_idx,
  output logic               out_last,
  output logic               frame_done,
  output logic               err_tile
`ifdef SSM_Y_NAN_CHECK_EN
  ,
  output logic [15:0]        nan_count
`endif
);

  localparam int unsigned TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int unsigned CW = $clog2(NUM_TILES + 1);

  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

  state_t               state, state_next;
  logic [NUM_TILES-1:0] bitmap;
  logic [CW-1:0]        tile_cnt;
  logic [DW-1:0]        mem [TOTAL];
  logic [TW-1:0]        tile_id;
  logic                 accept, in_range, dup, good, bad, handshake, last_hs;

  always_comb begin
    tile_ready = (state == COLLECT);
    out_valid  = (state == DRAIN);
    frame_done = (state == DONE);
    out_data   = mem[out_idx];
    out_last   = out_valid && (out_idx == IW'(TOTAL - 1));
    accept     = tile_valid && tile_ready && !clr;
    in_range   = (32'(tile_h_idx) < NUM_TILE_H) && (32'(tile_p_idx) < NUM_TILE_P);
    tile_id    = in_range ? TW'(32'(tile_h_idx) * NUM_TILE_P + 32'(tile_p_idx)) : '0;
    dup        = bitmap[tile_id];
    good       = accept && in_range && !dup;
    bad        = accept && !good;
    handshake  = out_valid && out_ready;
    last_hs    = handshake && (out_idx == IW'(TOTAL - 1));
    state_next = state;
    case (state)
      COLLECT: if (good && tile_cnt == CW'(NUM_TILES - 1)) state_next = DRAIN;
      DRAIN:   if (last_hs) state_next = DONE;
      DONE:    state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
    if (clr) state_next = COLLECT;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= COLLECT;
      bitmap   <= '0;
      tile_cnt <= '0;
      out_idx  <= '0;
      err_tile <= 1'b0;
    end else begin
      state    <= state_next;
      err_tile <= bad;
      if (clr || state == DONE) begin
        bitmap   <= '0;
        tile_cnt <= '0;
        out_idx  <= '0;
      end else begin
        if (good) begin
          bitmap[tile_id] <= 1'b1;
          tile_cnt        <= tile_cnt + 1'b1;
        end
        // wrap on the final handshake so out_idx never leaves the buffer range
        if (handshake) out_idx <= last_hs ? '0 : out_idx + 1'b1;
      end
    end
  end

  // Whole-tile scatter in one edge; the buffer itself is never reset.
  always_ff @(posedge clk) begin
    if (rst && good) begin
      for (int unsigned t = 0; t < TE; t++) begin
        mem[IW'((32'(tile_h_idx) * H_tile + t / P_tile) * P
                + 32'(tile_p_idx) * P_tile + t % P_tile)] <= y_tile[DW*t +: DW];
      end
    end
  end

`ifdef SSM_Y_NAN_CHECK_EN
  int unsigned nan_in_tile;
  logic [16:0] nan_sum;

  always_comb begin
    nan_in_tile = 0;
    for (int unsigned t = 0; t < TE; t++) begin
      if (y_tile[DW*t+10 +: 5] == 5'h1F && y_tile[DW*t +: 10] != '0) nan_in_tile += 1;
    end
    nan_sum = 17'(nan_count) + 17'(nan_in_tile);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      nan_count <= '0;
    end else if (clr || state == DONE) begin
      nan_count <= '0;
    end else if (good) begin
      nan_count <= nan_sum[16] ? 16'hFFFF : nan_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_ssm_y_tile_assembler.sv
// Directed/randomized bench for ssm_y_tile_assembler against an array-based model of the output frame.
module tb_ssm_y_tile_assembler;

  localparam int unsigned H = 24, P = 64, HT = 6, PT = 4, DW = 16;
  localparam int unsigned NTH = H / HT, NTP = P / PT, NT = NTH * NTP;
  localparam int unsigned TOTAL = H * P, TE = HT * PT, YW = TE * DW;

  logic          clk = 1'b0;
  logic          rst, clr, tile_valid, tile_ready, out_valid, out_ready;
  logic [1:0]    tile_h_idx;
  logic [3:0]    tile_p_idx;
  logic [YW-1:0] y_tile;
  logic [15:0]   out_data;
  logic [10:0]   out_idx;
  logic          out_last, frame_done, err_tile;
`ifdef SSM_Y_NAN_CHECK_EN
  logic [15:0]   nan_count;
`endif

  ssm_y_tile_assembler #(.B(1), .H(H), .P(P), .H_tile(HT), .P_tile(PT), .DW(DW)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_h_idx(tile_h_idx), .tile_p_idx(tile_p_idx), .y_tile(y_tile),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .frame_done(frame_done), .err_tile(err_tile)
`ifdef SSM_Y_NAN_CHECK_EN
    , .nan_count(nan_count)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] ref_mem [TOTAL];
  bit          got [NT];
  int unsigned got_cnt = 0;
  int unsigned nan_ref = 0;
  int unsigned order [NT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned flat(input int unsigned h, input int unsigned p, input int unsigned t);
    return (h * HT + t / PT) * P + p * PT + t % PT;
  endfunction

  function automatic bit is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

  function automatic logic [YW-1:0] flat_tile(input int unsigned h, input int unsigned p);
    logic [YW-1:0] d;
    for (int unsigned t = 0; t < TE; t++) d[DW*t +: DW] = 16'(flat(h, p, t));
    return d;
  endfunction

  function automatic logic [YW-1:0] fill_tile(input logic [15:0] v);
    logic [YW-1:0] d;
    for (int unsigned t = 0; t < TE; t++) d[DW*t +: DW] = v;
    return d;
  endfunction

  function automatic logic [YW-1:0] rand_tile();
    logic [YW-1:0] d;
    logic [15:0]   v;
    for (int unsigned t = 0; t < TE; t++) begin
      v = 16'($urandom);
      v[14] = 1'b0;
      d[DW*t +: DW] = v;
    end
    return d;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NT; i++) got[i] = 1'b0;
    got_cnt = 0;
    nan_ref = 0;
  endtask

  task automatic shuffle();
    int unsigned j, tmp;
    for (int unsigned i = 0; i < NT; i++) order[i] = i;
    for (int unsigned i = NT - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
  endtask

  task automatic send_tile(input int unsigned h, input int unsigned p, input logic [YW-1:0] d);
    bit exp_err;
    int unsigned n;
    exp_err = (h >= NTH) || (p >= NTP) ? 1'b1 : got[h * NTP + p];
    chk("tile_ready", tile_ready, 1);
    tile_h_idx = 2'(h);
    tile_p_idx = 4'(p);
    y_tile     = d;
    tile_valid = 1'b1;
    step();
    tile_valid = 1'b0;
    if (!exp_err) begin
      n = 0;
      for (int unsigned t = 0; t < TE; t++) begin
        ref_mem[flat(h, p, t)] = d[DW*t +: DW];
        if (is_nan(d[DW*t +: DW])) n++;
      end
      nan_ref = (nan_ref + n > 65535) ? 65535 : nan_ref + n;
      got[h * NTP + p] = 1'b1;
      got_cnt++;
    end
    chk("err_tile", err_tile, exp_err);
`ifdef SSM_Y_NAN_CHECK_EN
    chk("nan_count", nan_count, nan_ref);
`endif
    if (got_cnt < NT) chk("collect_no_valid", out_valid, 0);
    else              chk("drain_start", out_valid, 1);
  endtask

  task automatic drain(input int mode);
    int unsigned e = 0;
    int unsigned cyc = 0;
    bit rdy;
    while (e < TOTAL && cyc < 20000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      chk("out_valid", out_valid, 1);
      chk("out_idx", out_idx, e);
      chk("out_data", out_data, ref_mem[e]);
      chk("out_last", out_last, (e == TOTAL - 1));
      step();
      cyc++;
      if (rdy) e++;
    end
    out_ready = 1'b0;
    chk("drain_count", e, TOTAL);
    chk("frame_done", frame_done, 1);
    chk("done_no_valid", out_valid, 0);
`ifdef SSM_Y_NAN_CHECK_EN
    chk("nan_hold", nan_count, nan_ref);
`endif
    step();
    clear_model();
    chk("frame_done_pulse", frame_done, 0);
    chk("ready_after_done", tile_ready, 1);
`ifdef SSM_Y_NAN_CHECK_EN
    chk("nan_after_done", nan_count, 0);
`endif
  endtask

  initial begin
    logic [YW-1:0] d;
    rst = 1'b0; clr = 1'b0; tile_valid = 1'b0; out_ready = 1'b0;
    tile_h_idx = '0; tile_p_idx = '0; y_tile = '0;
    clear_model();
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("rst_tile_ready", tile_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_tile", err_tile, 0);
    chk("rst_out_last", out_last, 0);
`ifdef SSM_Y_NAN_CHECK_EN
    chk("rst_nan", nan_count, 0);
`endif

    // Raster fill, value = flat index, no backpressure
    for (int unsigned h = 0; h < NTH; h++)
      for (int unsigned p = 0; p < NTP; p++) send_tile(h, p, flat_tile(h, p));
    drain(0);

    // Duplicate (0,0), then reverse fill of the rest; drain with 1,0,0,1 backpressure
    send_tile(0, 0, fill_tile(16'h1111));
    send_tile(0, 0, fill_tile(16'h2222));
    step();
    chk("err_one_pulse", err_tile, 0);
    for (int h = NTH - 1; h >= 0; h--)
      for (int p = NTP - 1; p >= 0; p--)
        if (h != 0 || p != 0) send_tile(h, p, flat_tile(h, p));
    chk("dup_kept_y0", ref_mem[0], 16'h1111);
    drain(1);

    // Abort after 10 tiles, clr colliding with tile_valid, then a random-order frame
    shuffle();
    for (int unsigned i = 0; i < 10; i++) send_tile(order[i] / NTP, order[i] % NTP, rand_tile());
    clr = 1'b1;
    step();
    clr = 1'b0;
    clear_model();
    chk("clr_ready", tile_ready, 1);
    chk("clr_no_valid", out_valid, 0);
    chk("clr_no_done", frame_done, 0);
    clr = 1'b1; tile_valid = 1'b1; tile_h_idx = '0; tile_p_idx = '0; y_tile = rand_tile();
    step();
    clr = 1'b0; tile_valid = 1'b0;
    chk("clr_tile_no_err", err_tile, 0);
    chk("clr_tile_no_valid", out_valid, 0);
    shuffle();
    for (int unsigned i = 0; i < NT; i++) begin
      d = rand_tile();
      if (i == 0) begin
        d[DW*0 +: DW]  = 16'h7E00;
        d[DW*5 +: DW]  = 16'h7E00;
        d[DW*23 +: DW] = 16'h7E00;
      end
      send_tile(order[i] / NTP, order[i] % NTP, d);
    end
    drain(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ssm_y_tile_assembler.md
Name: ssm_y_tile_assembler

Overview:
- Hardware downstream stage of ssm_block_fp16_top in the tiled SSM flow.
- Accepts one y_tile (H_tile*P_tile FP16 outputs) per tile completion, together with its (h_idx, p_idx) tile coordinates.
- Scatters each tile into a full B*H*P output buffer at the correct (h_abs, p_abs) positions.
- Once every tile of the frame is present, streams the assembled y vector out in flat order with a valid/ready handshake.

Parameters:
- B, 1, batch size; only B=1 is supported.
- H, 24, number of heads.
- P, 64, head dimension.
- H_tile, 6, heads per tile; H % H_tile must be 0.
- P_tile, 4, head-dim elements per tile; P % P_tile must be 0.
- DW, 16, element width (FP16).
- Derived: NUM_TILE_H = H/H_tile, NUM_TILE_P = P/P_tile, NUM_TILES = NUM_TILE_H*NUM_TILE_P, TOTAL = B*H*P, HW = max(1,$clog2(NUM_TILE_H)), PW = max(1,$clog2(NUM_TILE_P)), IW = $clog2(TOTAL).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- clr  in  1  synchronous frame abort/restart pulse.
- tile_valid  in  1  y_tile and indices are valid.
- tile_ready  out  1  assembler can accept a tile.
- tile_h_idx  in  HW  tile row index.
- tile_p_idx  in  PW  tile column index.
- y_tile  in  H_tile*P_tile*DW  tile data; element t sits at bits [DW*t +: DW], with h_rel = t/P_tile and p_rel = t%P_tile.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DW  element y[out_idx].
- out_idx  out  IW  flat index, equal to h_abs*P + p_abs.
- out_last  out  1  high with the element at index TOTAL-1.
- frame_done  out  1  one-cycle pulse after the last element is accepted.
- err_tile  out  1  one-cycle pulse on a rejected tile.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=COLLECT, tile bitmap cleared, tile_cnt=0, out_idx=0.
  - out_valid=0, out_last=0, frame_done=0, err_tile=0.
  - tile_ready=1 from the first cycle after reset.
  - The buffer RAM is not cleared.
- A tile is accepted when tile_valid && tile_ready && !clr.
- State COLLECT:
  - tile_ready=1.
  - On accept with an in-range, not-yet-received tile:
    - In the same edge, write all H_tile*P_tile elements to buf[(h_idx*H_tile+h_rel)*P + p_idx*P_tile+p_rel].
    - Set the bitmap bit h_idx*NUM_TILE_P+p_idx.
    - Increment tile_cnt.
  - Duplicate tile, or out-of-range index (h_idx>=NUM_TILE_H or p_idx>=NUM_TILE_P):
    - Data is discarded; bitmap and tile_cnt are unchanged.
    - err_tile=1 on the next cycle, for one cycle.
  - When the accepted tile makes tile_cnt==NUM_TILES, move to DRAIN on that edge. Tile arrival order is arbitrary.
- State DRAIN:
  - tile_ready=0, out_valid=1.
  - out_data = buf[out_idx], out_last = (out_idx==TOTAL-1).
  - First element is presented the cycle after the last tile is accepted (latency 1).
  - On out_valid&&out_ready: out_idx increments.
  - Without out_ready, out_data, out_idx and out_last hold stable.
  - On the handshake at TOTAL-1, move to DONE.
- State DONE:
  - Lasts one cycle: frame_done=1, out_valid=0.
  - Bitmap, tile_cnt and out_idx are cleared.
  - Next state is COLLECT.
- clr=1 in any state:
  - Next state is COLLECT; bitmap, tile_cnt and out_idx are cleared; out_valid=0.
  - No tile is accepted in that cycle; frame_done is not pulsed.
- rst takes priority over clr.
- out_valid never drops without a handshake except on clr or rst.

Optional Feature:
- Macro: SSM_Y_NAN_CHECK_EN.
- When defined:
  - Adds output port nan_count, 16 bits.
  - Counts accepted-tile elements whose exponent is 5'h1F and mantissa is non-zero (FP16 NaN).
  - Adds the count of NaN elements in each accepted tile in the same edge; saturates at 16'hFFFF.
  - Cleared by rst, clr and DONE; holds its value during DRAIN.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> tile_ready=1, out_valid=0, frame_done=0, err_tile=0 on the first cycle after release.
- Raster fill with defaults (64 tiles, each element value = its flat index), out_ready=1:
  - 1536 outputs 16'h0000..16'h05FF in order.
  - out_last only at out_idx=0x5FF.
  - frame_done pulses exactly 1 cycle later.
- Reverse-order fill (h_idx 3→0, p_idx 15→0) with the same data -> output stream identical to the raster case.
- Duplicate and out-of-range tiles:
  - Tile (0,0) sent with 16'h1111, then again with 16'h2222 -> err_tile pulses once; y[0]=16'h1111 after drain; still requires all 64 distinct tiles.
  - tile_h_idx=3, tile_p_idx=15 is in range (last tile) and is accepted; out-of-range indices only occur with non-default parameters where the index width exceeds the tile count.
- Backpressure: out_ready pattern 1,0,0,1 repeating -> no skipped or duplicated indices; out_data stable while stalled; 1536 handshakes in total.
- clr after 10 accepted tiles, and clr asserted together with tile_valid -> that tile is not accepted; DRAIN starts only after 64 further distinct tiles.
- With SSM_Y_NAN_CHECK_EN: 3 elements of 16'h7E00 in one tile -> nan_count=3; then 0 after DONE.
